// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request bus between the requesters and rf_wb_arbiter
interface rf_wb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 3,
    parameter int AW    = 5
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ*XLEN-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin RF writeback arbiter with per-register busy scoreboard
// Optional forwarding of the in-flight RF write to rs1/rs2 under `RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 3,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  wb,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_set_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
`ifdef RF_WB_BYPASS_EN
    output logic [XLEN-1:0] rs1_fwd,
    output logic [XLEN-1:0] rs2_fwd,
    output logic            rs1_fwd_vld,
    output logic            rs2_fwd_vld,
`endif
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);
    localparam int              PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int              NREG   = 1 << AW;
    localparam logic [PW:0]     NREQ_W = (PW+1)'(N_REQ);
    localparam logic [PW-1:0]   LAST   = PW'(N_REQ - 1);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    cand;
    logic [PW:0]      sum;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic [AW-1:0]    win_addr;
    logic [XLEN-1:0]  win_data;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  clr_mask;

    // Scan from rr_ptr upward with wraparound; first valid requester wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[PW-1:0];
            if (!found && !rst && wb.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
    end

    assign wb.req_ready = grant;
    assign win_addr     = wb.req_addr[win*AW +: AW];
    assign win_data     = wb.req_data[win*XLEN +: XLEN];

    // x0 never becomes busy, so busy[0] stays 0 and zero-address queries read 0.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_set && (sb_set_addr != '0)) begin
            set_mask[sb_set_addr] = 1'b1;
        end
        if (rf_wen && (rf_waddr != '0)) begin
            clr_mask[rf_waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
        end else begin
            if (found) begin
                rr_ptr   <= (win == LAST) ? '0 : win + 1'b1;
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
            rf_wen <= found && (win_addr != '0);
            // Set is applied after clear so a same-cycle re-issue keeps the register busy.
            busy   <= (busy & ~clr_mask) | set_mask;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd_vld = rf_wen && (rf_waddr == rs1_addr) && (rs1_addr != '0);
    assign rs2_fwd_vld = rf_wen && (rf_waddr == rs2_addr) && (rs2_addr != '0);
    assign rs1_fwd     = rs1_fwd_vld ? rf_wdata : '0;
    assign rs2_fwd     = rs2_fwd_vld ? rf_wdata : '0;
    assign rs1_busy    = busy[rs1_addr] & ~rs1_fwd_vld;
    assign rs2_busy    = busy[rs2_addr] & ~rs2_fwd_vld;
`else
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];
`endif
    assign rd_busy     = busy[rd_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int N_REQ = 3;
    localparam int AW    = 5;

    typedef struct {
        bit        wen;
        bit [4:0]  addr;
        bit [31:0] data;
    } wr_t;

    logic            clk;
    logic            rst;
    logic            sb_set;
    logic [AW-1:0]   sb_set_addr, rs1_addr, rs2_addr, rd_addr;
    logic            rs1_busy, rs2_busy, rd_busy;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            rs1_fwd_vld, rs2_fwd_vld;
`endif

    rf_wb_arbiter_if #(.XLEN(XLEN), .N_REQ(N_REQ), .AW(AW)) wb ();

    rf_wb_arbiter #(.XLEN(XLEN), .N_REQ(N_REQ), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wb(wb.slave),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
`ifdef RF_WB_BYPASS_EN
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .rs1_fwd_vld(rs1_fwd_vld), .rs2_fwd_vld(rs2_fwd_vld),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q[$];

    // Model state: what the register file port and scoreboard hold in the current cycle.
    int        rr_m;
    bit        busy_m [32];
    bit        cur_wen;
    bit [4:0]  cur_addr;
    bit [31:0] cur_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_src_busy(input logic [4:0] a);
`ifdef RF_WB_BYPASS_EN
        return busy_m[a] && !(cur_wen && cur_addr == a && a != 0);
`else
        return busy_m[a];
`endif
    endfunction

    // Reference model: evaluated mid-cycle once inputs are stable.
    initial begin
        rr_m = 0;
        cur_wen = 0;
        cur_addr = 0;
        cur_data = 0;
        busy_m = '{default: 0};
        forever begin
            @(negedge clk);
            begin
                int       w;
                int       idx;
                wr_t      e;
                bit [2:0] exp_ready;
                if (rst) begin
                    rr_m    = 0;
                    busy_m  = '{default: 0};
                    cur_wen = 0;
                end
                w = -1;
                if (!rst) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        idx = (rr_m + k) % N_REQ;
                        if (w < 0 && wb.req_valid[idx]) w = idx;
                    end
                end
                exp_ready = (w >= 0) ? (3'b001 << w) : 3'b000;
                check("req_ready", 32'(wb.req_ready), 32'(exp_ready));
                check("rs1_busy", 32'(rs1_busy), 32'(exp_src_busy(rs1_addr)));
                check("rs2_busy", 32'(rs2_busy), 32'(exp_src_busy(rs2_addr)));
                check("rd_busy", 32'(rd_busy), 32'(busy_m[rd_addr]));
`ifdef RF_WB_BYPASS_EN
                check("rs1_fwd_vld", 32'(rs1_fwd_vld), 32'(cur_wen && cur_addr == rs1_addr && rs1_addr != 0));
                check("rs1_fwd", rs1_fwd, (cur_wen && cur_addr == rs1_addr && rs1_addr != 0) ? cur_data : 32'h0);
`endif
                if (!rst) begin
                    if (cur_wen && cur_addr != 0) busy_m[cur_addr] = 0;
                    if (sb_set && sb_set_addr != 0) busy_m[sb_set_addr] = 1;
                end
                e.wen  = 0;
                e.addr = 0;
                e.data = 0;
                if (w >= 0) begin
                    e.addr = wb.req_addr[w*AW +: AW];
                    e.data = wb.req_data[w*XLEN +: XLEN];
                    e.wen  = (e.addr != 0);
                    rr_m   = (w + 1) % N_REQ;
                end
                exp_q.push_back(e);
                cur_wen  = e.wen;
                cur_addr = e.addr;
                cur_data = e.data;
            end
        end
    end

    // Monitor: registered RF port against the scoreboard queue.
    initial begin
        @(negedge clk);
        forever begin
            @(posedge clk);
            #2;
            begin
                wr_t e;
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    if (rst) begin
                        check("rf_wen_rst", 32'(rf_wen), 32'd0);
                        check("rf_waddr_rst", 32'(rf_waddr), 32'd0);
                        check("rf_wdata_rst", rf_wdata, 32'd0);
                    end else begin
                        check("rf_wen", 32'(rf_wen), 32'(e.wen));
                        if (e.wen) begin
                            check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                            check("rf_wdata", rf_wdata, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        wb.req_valid = '0;
        sb_set = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        wb.req_addr[i*AW +: AW]     = a;
        wb.req_data[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        rst = 1'b1;
        wb.req_valid = 3'b111;
        for (int i = 0; i < N_REQ; i++) set_req(i, 5'(i + 1), 32'h1000 + i);
        sb_set = 1'b0;
        sb_set_addr = '0;
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        rd_addr = 5'd3;
        step(3);
        rst = 1'b0;
        step(6);

        // Scoreboard lifecycle on x5
        idle();
        sb_set = 1'b1; sb_set_addr = 5'd5; rs1_addr = 5'd5;
        step(1);
        sb_set = 1'b0;
        step(3);
        wb.req_valid = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
        step(1);
        idle();
        step(3);

        // x0 write and x0 set
        wb.req_valid = 3'b001; set_req(0, 5'd0, 32'h1234);
        sb_set = 1'b1; sb_set_addr = 5'd0; rs1_addr = 5'd0;
        step(1);
        idle();
        step(2);

        // Set/clear collision on x7
        sb_set = 1'b1; sb_set_addr = 5'd7; rs1_addr = 5'd7; rd_addr = 5'd7;
        step(1);
        sb_set = 1'b0;
        wb.req_valid = 3'b001; set_req(0, 5'd7, 32'h7777_0007);
        step(1);
        idle();
        sb_set = 1'b1; sb_set_addr = 5'd7;
        step(1);
        sb_set = 1'b0;
        step(2);

        // Async reset between grant and write
        wb.req_valid = 3'b100; set_req(2, 5'd9, 32'hCAFE_0009);
        sb_set = 1'b1; sb_set_addr = 5'd9; rs2_addr = 5'd9;
        step(1);
        sb_set = 1'b0;
        step(1);
        rst = 1'b1;
        idle();
        step(1);
        rst = 1'b0;
        wb.req_valid = 3'b111;
        step(3);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            logic [4:0] a;
            wb.req_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < N_REQ; i++) set_req(i, 5'($urandom_range(0, 7)), $urandom());
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            rd_addr  = 5'($urandom_range(0, 7));
            a = 5'($urandom_range(0, 7));
            sb_set = ($urandom_range(0, 2) == 0) && (!busy_m[a] || (cur_wen && cur_addr == a));
            sb_set_addr = a;
            rst = ($urandom_range(0, 99) == 0);
            step(1);
        end
        rst = 1'b0;
        idle();
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single write port of the integer register file (32 x XLEN; x0 reads zero).
- Arbitrates writeback requests from N_REQ sources (index 0 = EXU, 1 = LSU, 2 = CSR) with round-robin priority.
- Registers the winning write onto the RF port.
- Keeps a busy scoreboard per architectural register so decode can stall on RAW and WAW hazards.

Parameters:
- XLEN, 32, register data width.
- N_REQ, 3, number of writeback requesters (2..4).
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N_REQ  requester i has a writeback pending.
- req_ready  output  N_REQ  requester i granted this cycle; combinational from req_valid and rr_ptr.
- req_addr  input  N_REQ*AW  destination register of requester i, at slice [i*AW +: AW].
- req_data  input  N_REQ*XLEN  write data of requester i, at slice [i*XLEN +: XLEN].
- sb_set  input  1  decode issues an instruction that writes sb_set_addr.
- sb_set_addr  input  AW  destination register being issued.
- rs1_addr  input  AW  decode source-1 query.
- rs2_addr  input  AW  decode source-2 query.
- rd_addr  input  AW  decode destination query.
- rs1_busy  output  1  rs1_addr has an outstanding write.
- rs2_busy  output  1  rs2_addr has an outstanding write.
- rd_busy  output  1  rd_addr has an outstanding write.
- rf_wen  output  1  RF write enable.
- rf_waddr  output  AW  RF write address.
- rf_wdata  output  XLEN  RF write data.

Behaviour:
- Reset (async, rst=1):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy[31:0]=0; rr_ptr=0.
  - All req_ready=0 while rst=1.
- Arbitration:
  - Search starts at rr_ptr and runs upward modulo N_REQ. The first valid requester wins; at most one req_ready is high per cycle.
  - A handshake is req_valid[i] & req_ready[i].
  - After a handshake, rr_ptr <= (winner+1) mod N_REQ. With no handshake, rr_ptr holds.
  - There is no back-pressure from the RF, so any valid requester is granted within N_REQ cycles.
- Write pipeline:
  - Handshake at cycle t drives rf_wen=1, rf_waddr and rf_wdata (the winner's values) during cycle t+1.
  - The RF captures the write at the end of t+1. Latency from grant to RF update is 1 cycle.
  - With no handshake at cycle t, rf_wen=0 during t+1; rf_waddr and rf_wdata hold their last values.
  - A request to x0 is granted and handshaken normally, but rf_wen stays 0 and no busy bit changes.
- Scoreboard:
  - sb_set=1 with sb_set_addr!=0 sets busy[sb_set_addr] at the clock edge. sb_set_addr=0 is ignored.
  - When rf_wen=1 and rf_waddr!=0, busy[rf_waddr] clears at the end of that cycle, i.e. the same edge the RF captures the data.
  - Set and clear to the same address in the same cycle: set wins, busy stays 1.
  - sb_set to an already-busy register is illegal. Decode must stall on rd_busy; the block does not queue a second pending write.
  - rs1_busy = busy[rs1_addr], rs2_busy = busy[rs2_addr], rd_busy = busy[rd_addr], all combinational. The result for address 0 is always 0.
  - A requester writing a register that is not busy still writes the RF; busy stays 0.
- Reset asserted mid-operation clears busy and rr_ptr immediately. A grant in flight is dropped: rf_wen=0 on the first edge after reset is released.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd and rs2_fwd (XLEN each) and rs1_fwd_vld and rs2_fwd_vld (1 each).
  - When rf_wen=1 and rf_waddr==rsN_addr!=0: rsN_fwd_vld=1, rsN_fwd=rf_wdata and rsN_busy=0 in that same cycle, so decode may issue one cycle earlier.
  - Otherwise rsN_fwd_vld=0 and rsN_fwd=0.
- Undefined: none of these ports exist; busy is reported strictly from the busy bits.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all req_valid=1.
  - Expect req_ready=0, rf_wen=0, all busy outputs 0.
  - After release, the first grant goes to requester 0.
- Round-robin: req_valid=3'b111 held for 6 cycles.
  - Expect grant order 0,1,2,0,1,2.
  - rf_wen=1 on each following cycle, with rf_waddr/rf_wdata matching each winner.
- Scoreboard lifecycle:
  - sb_set to x5 at cycle 0. Expect rs1_busy=1 for rs1_addr=5 from cycle 1.
  - LSU writes x5 = 32'hDEADBEEF, granted at cycle 4. Expect rf_wen=1 at cycle 5 and rs1_busy=0 from cycle 6 (without bypass).
- x0 write: EXU writes addr 0, data 32'h1234.
  - Expect req_ready=1 and rf_wen=0 on the following cycle.
  - rs1_busy stays 0 for rs1_addr=0 even after sb_set with addr 0.
- Set/clear collision: x7 busy; its write reaches the RF at cycle t while sb_set to x7 also occurs at t.
  - Expect busy[7]=1 at t+1.
- Async reset mid-flight: assert rst between a grant and its write cycle.
  - Expect rf_wen=0 immediately, all busy bits cleared, rr_ptr=0.
